// File: rtl/imem_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_arbiter
// Purpose  : Shares the single combinational read port of a byte-addressed,
//            big-endian instruction memory between the CPU fetch stage and
//            a debug/monitor read port.
//            - The CPU has fixed priority.
//            - A starvation counter forces a debug grant after STARVE_LIMIT
//              consecutive CPU grants made while debug was waiting.
//            - Each access checks alignment and range. A legal address is
//              registered onto IAddr for one READ cycle. An illegal address
//              is answered directly with a fault and never reaches memory.
// Ports    : CLK, Reset       clock, asynchronous active-high reset
//            cpu_req/addr     CPU request, held with the address until ack
//            cpu_ack          one-cycle pulse; cpu_data/cpu_fault valid
//            cpu_data/fault   registered response, held until next cpu_ack
//            dbg_*            debug port, same protocol as the CPU port
//            IAddr            registered address to the instruction memory
//            IDataIn          combinational word returned for IAddr
//            busy             high whenever the sequencer is not idle
//            fetch_cnt        (optional) acks issued, modulo 2^16
//            fault_cnt        (optional) faulting acks issued, modulo 2^16
// Options  : define IMEM_FETCH_STATS_EN to add fetch_cnt / fault_cnt.
// Revision : 1.0  initial release
// ============================================================================
module imem_fetch_arbiter #(
  parameter int unsigned MEM_BYTES    = 256,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ack,
  output logic [31:0] cpu_data,
  output logic        cpu_fault,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_ack,
  output logic [31:0] dbg_data,
  output logic        dbg_fault,
  output logic [31:0] IAddr,
  input  logic [31:0] IDataIn,
  output logic        busy
`ifdef IMEM_FETCH_STATS_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] fault_cnt
`endif
);

  // Highest legal word address. It is compared at 33 bits so an address
  // near 0xFFFFFFFF cannot wrap around into the legal range.
  localparam logic [32:0] LAST_WORD  = 33'(MEM_BYTES - 4);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            state_q,     state_d;
  logic              owner_q,     owner_d;     // 1 = debug owns the access
  logic              fault_q,     fault_d;
  logic [31:0]       addr_q,      addr_d;      // doubles as IAddr
  logic [CNT_W-1:0]  starve_q,    starve_d;
  logic              cpu_ack_q,   cpu_ack_d;
  logic [31:0]       cpu_data_q,  cpu_data_d;
  logic              cpu_fault_q, cpu_fault_d;
  logic              dbg_ack_q,   dbg_ack_d;
  logic [31:0]       dbg_data_q,  dbg_data_d;
  logic              dbg_fault_q, dbg_fault_d;

  // --------------------------------------------------------------------------
  // Arbitration and legality of the current winner
  // --------------------------------------------------------------------------
  logic        any_req;
  logic        starve_hit;
  logic        dbg_wins;
  logic [31:0] win_addr;
  logic        win_legal;

  assign any_req    = cpu_req | dbg_req;
  assign starve_hit = (starve_q == STARVE_MAX);
  // Debug wins when it is alone, or when it has waited through the limit.
  assign dbg_wins   = dbg_req & (~cpu_req | starve_hit);
  assign win_addr   = dbg_wins ? dbg_addr : cpu_addr;
  assign win_legal  = (win_addr[1:0] == 2'b00) && ({1'b0, win_addr} <= LAST_WORD);

  // Response loaded into the owner's output registers on entry to RESP.
  // Both the IDLE fault path and the READ path funnel through these signals,
  // so the ack, fault and data of a port always change together.
  logic        enter_resp;
  logic        resp_dbg;
  logic        resp_fault;
  logic [31:0] resp_data;

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    fault_d     = fault_q;
    addr_d      = addr_q;
    starve_d    = starve_q;
    cpu_ack_d   = 1'b0;
    cpu_data_d  = cpu_data_q;
    cpu_fault_d = cpu_fault_q;
    dbg_ack_d   = 1'b0;
    dbg_data_d  = dbg_data_q;
    dbg_fault_d = dbg_fault_q;
    enter_resp  = 1'b0;
    resp_dbg    = owner_q;
    resp_fault  = fault_q;
    resp_data   = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = dbg_wins;
          fault_d = ~win_legal;

          // The counter only tracks CPU grants made while debug waits.
          if (dbg_wins || !dbg_req) begin
            starve_d = '0;
          end else if (!starve_hit) begin
            starve_d = starve_q + CNT_W'(1);
          end

          if (win_legal) begin
            addr_d  = win_addr;
            state_d = ST_READ;
          end else begin
            // Illegal address: skip the memory entirely and answer now.
            // IAddr keeps its previous value.
            enter_resp = 1'b1;
            resp_dbg   = dbg_wins;
            resp_fault = 1'b1;
            resp_data  = 32'h0;
            state_d    = ST_RESP;
          end
        end
      end

      ST_READ: begin
        enter_resp = 1'b1;
        resp_dbg   = owner_q;
        resp_fault = fault_q;
        resp_data  = fault_q ? 32'h0 : IDataIn;
        state_d    = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enter_resp) begin
      if (resp_dbg) begin
        dbg_ack_d   = 1'b1;
        dbg_fault_d = resp_fault;
        dbg_data_d  = resp_data;
      end else begin
        cpu_ack_d   = 1'b1;
        cpu_fault_d = resp_fault;
        cpu_data_d  = resp_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      fault_q     <= 1'b0;
      addr_q      <= 32'h0;
      starve_q    <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_data_q  <= 32'h0;
      cpu_fault_q <= 1'b0;
      dbg_ack_q   <= 1'b0;
      dbg_data_q  <= 32'h0;
      dbg_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      fault_q     <= fault_d;
      addr_q      <= addr_d;
      starve_q    <= starve_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_data_q  <= cpu_data_d;
      cpu_fault_q <= cpu_fault_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_data_q  <= dbg_data_d;
      dbg_fault_q <= dbg_fault_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional statistics counters
  // --------------------------------------------------------------------------
`ifdef IMEM_FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] fault_cnt_q, fault_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    fault_cnt_d = fault_cnt_q;
    if (enter_resp) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
      if (resp_fault) begin
        fault_cnt_d = fault_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fetch_cnt_q <= 16'h0;
      fault_cnt_q <= 16'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign fault_cnt = fault_cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cpu_ack   = cpu_ack_q;
  assign cpu_data  = cpu_data_q;
  assign cpu_fault = cpu_fault_q;
  assign dbg_ack   = dbg_ack_q;
  assign dbg_data  = dbg_data_q;
  assign dbg_fault = dbg_fault_q;
  assign IAddr     = addr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_arbiter
// Purpose  : Self-checking bench for imem_fetch_arbiter. Requesters push the
//            expected response into a per-port queue; a monitor pops and
//            compares on every ack.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_fetch_arbiter;

  localparam int unsigned MEM_BYTES    = 256;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int unsigned CNT_W        = 3;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic        cpu_ack;
  logic [31:0] cpu_data;
  logic        cpu_fault;
  logic        dbg_req = 1'b0;
  logic [31:0] dbg_addr = 32'h0;
  logic        dbg_ack;
  logic [31:0] dbg_data;
  logic        dbg_fault;
  logic [31:0] IAddr;
  logic [31:0] IDataIn;
  logic        busy;
`ifdef IMEM_FETCH_STATS_EN
  logic [15:0] fetch_cnt;
  logic [15:0] fault_cnt;
`endif

  imem_fetch_arbiter #(
    .MEM_BYTES   (MEM_BYTES),
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_ack  (cpu_ack),
    .cpu_data (cpu_data),
    .cpu_fault(cpu_fault),
    .dbg_req  (dbg_req),
    .dbg_addr (dbg_addr),
    .dbg_ack  (dbg_ack),
    .dbg_data (dbg_data),
    .dbg_fault(dbg_fault),
    .IAddr    (IAddr),
    .IDataIn  (IDataIn),
    .busy     (busy)
`ifdef IMEM_FETCH_STATS_EN
    ,
    .fetch_cnt(fetch_cnt),
    .fault_cnt(fault_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Big-endian byte memory behind the combinational read port.
  logic [7:0] mem [MEM_BYTES];
  always_comb begin
    IDataIn = 32'hDEAD_BEEF;
    if (IAddr <= 32'(MEM_BYTES - 4))
      IDataIn = {mem[IAddr[7:0]], mem[IAddr[7:0] + 8'd1],
                 mem[IAddr[7:0] + 8'd2], mem[IAddr[7:0] + 8'd3]};
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: {fault, data} for a byte address.
  function automatic logic [32:0] model(input logic [31:0] a);
    longint unsigned la = 64'(a);
    if (a[1:0] != 2'b00 || la + 4 > 64'(MEM_BYTES)) return {1'b1, 32'h0};
    return {1'b0, mem[a[7:0]], mem[a[7:0] + 8'd1], mem[a[7:0] + 8'd2], mem[a[7:0] + 8'd3]};
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return {22'h0, 8'($urandom_range(0, 63)), 2'b00};
      2:       return {24'h0, 8'($urandom_range(0, 255))};
      3:       return 32'd252;
      4:       return ($urandom_range(0, 1) == 0) ? 32'd256 : 32'hFFFF_FFFC;
      default: return 32'($urandom);
    endcase
  endfunction

  logic [32:0] cpu_q[$];
  logic [32:0] dbg_q[$];
  bit          order_q[$];   // 0 = CPU ack, 1 = debug ack

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic        cpu_prev = 1'b0;
  logic        dbg_prev = 1'b0;
  logic [32:0] mon_e;

  always @(negedge CLK) begin
    if (Reset) begin
      cpu_prev = 1'b0;
      dbg_prev = 1'b0;
    end else begin
      if (cpu_ack) begin
        chk("cpu_ack_pulse", 33'(cpu_prev), 33'(0));
        if (cpu_q.size() == 0) chk("cpu_unexpected_ack", 33'(1), 33'(0));
        else begin
          mon_e = cpu_q.pop_front();
          chk("cpu_data", 33'(cpu_data), 33'(mon_e[31:0]));
          chk("cpu_fault", 33'(cpu_fault), 33'(mon_e[32]));
        end
        order_q.push_back(1'b0);
      end
      if (dbg_ack) begin
        chk("dbg_ack_pulse", 33'(dbg_prev), 33'(0));
        if (dbg_q.size() == 0) chk("dbg_unexpected_ack", 33'(1), 33'(0));
        else begin
          mon_e = dbg_q.pop_front();
          chk("dbg_data", 33'(dbg_data), 33'(mon_e[31:0]));
          chk("dbg_fault", 33'(dbg_fault), 33'(mon_e[32]));
        end
        order_q.push_back(1'b1);
      end
      cpu_prev = cpu_ack;
      dbg_prev = dbg_ack;
    end
  end

  // --------------------------------------------------------------------------
  // One request on one port. Called at posedge+1; returns at posedge+1 after
  // the ack with req dropped. exp_lat >= 0 additionally checks latency and
  // IAddr (only meaningful when the other port is quiet).
  // --------------------------------------------------------------------------
  task automatic xfer(input bit is_dbg, input logic [31:0] addr,
                      input int exp_lat, input bit drop_early);
    logic [31:0] prior_iaddr;
    logic [32:0] e;
    int          lat;
    logic        ack;
    prior_iaddr = IAddr;
    e           = model(addr);
    lat         = -1;
    if (is_dbg) begin
      dbg_q.push_back(e); dbg_addr = addr; dbg_req = 1'b1;
    end else begin
      cpu_q.push_back(e); cpu_addr = addr; cpu_req = 1'b1;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (drop_early && c == 1) begin
        if (is_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
      end
      if (exp_lat > 0 && !e[32] && c == 1) begin
        chk("iaddr_in_read", 33'(IAddr), 33'(addr));
        chk("busy_in_read", 33'(busy), 33'(1));
      end
      ack = is_dbg ? dbg_ack : cpu_ack;
      if (ack) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) chk(is_dbg ? "dbg_ack_timeout" : "cpu_ack_timeout", 33'(0), 33'(1));
    else if (exp_lat >= 0) begin
      chk("ack_latency", 33'(lat), 33'(exp_lat));
      chk("iaddr_after", 33'(IAddr), 33'(e[32] ? prior_iaddr : addr));
    end
    @(posedge CLK);
    #1;
    if (is_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
  endtask

  task automatic do_reset();
    Reset   = 1'b1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    cpu_q.delete();
    dbg_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_ack"},   33'(cpu_ack),   33'(0));
    chk({tag, "_cpu_data"},  33'(cpu_data),  33'(0));
    chk({tag, "_cpu_fault"}, 33'(cpu_fault), 33'(0));
    chk({tag, "_dbg_ack"},   33'(dbg_ack),   33'(0));
    chk({tag, "_dbg_data"},  33'(dbg_data),  33'(0));
    chk({tag, "_dbg_fault"}, 33'(dbg_fault), 33'(0));
    chk({tag, "_iaddr"},     33'(IAddr),     33'(0));
    chk({tag, "_busy"},      33'(busy),      33'(0));
`ifdef IMEM_FETCH_STATS_EN
    chk({tag, "_fetch_cnt"}, 33'(fetch_cnt), 33'(0));
    chk({tag, "_fault_cnt"}, 33'(fault_cnt), 33'(0));
`endif
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    bit exp_order[$];
    int nc, nd, cnt, ack_seen;

    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'($urandom);
    mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;

    do_reset();
    @(negedge CLK);
    chk_all_zero("reset");
    @(posedge CLK);
    #1;

    // Directed single accesses, with latency and IAddr checks.
    xfer(1'b0, 32'h0000_0000, 2, 1'b0);
    chk("first_word", 33'(cpu_data), 33'(32'h8C01_0004));
    xfer(1'b0, 32'h0000_0002, 1, 1'b0);
    xfer(1'b0, 32'hFFFF_FFFC, 1, 1'b0);
    xfer(1'b0, 32'd256,       1, 1'b0);
    xfer(1'b0, 32'd252,       2, 1'b0);
    xfer(1'b1, 32'd16,        2, 1'b0);
    xfer(1'b1, 32'h0000_0003, 1, 1'b0);
    xfer(1'b0, 32'd40,        2, 1'b1);   // req dropped before ack

    // Starvation: both held high; order follows the counter rule.
    do_reset();
    order_q.delete();
    nc = 6; nd = 2; cnt = 0;
    while (nc > 0 || nd > 0) begin
      if (nd > 0 && (nc == 0 || cnt == int'(STARVE_LIMIT))) begin
        exp_order.push_back(1'b1); nd--; cnt = 0;
      end else begin
        exp_order.push_back(1'b0); nc--;
        cnt = (nd > 0) ? ((cnt < int'(STARVE_LIMIT)) ? cnt + 1 : cnt) : 0;
      end
    end
    fork
      for (int i = 0; i < 6; i++) xfer(1'b0, {22'h0, 8'(i * 3), 2'b00}, -1, 1'b0);
      for (int i = 0; i < 2; i++) xfer(1'b1, {22'h0, 8'(100 + i), 2'b00}, -1, 1'b0);
    join
    chk("order_len", 33'(order_q.size()), 33'(exp_order.size()));
    for (int i = 0; i < exp_order.size() && i < order_q.size(); i++)
      chk($sformatf("grant_order[%0d]", i), 33'(order_q[i]), 33'(exp_order[i]));

    // Reset in the middle of a READ: no ack afterwards, outputs cleared.
    cpu_addr = 32'd4;
    cpu_req  = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("busy_before_abort", 33'(busy), 33'(1));
    #1;
    Reset   = 1'b1;
    cpu_req = 1'b0;
    #2;
    chk_all_zero("abort");
    @(posedge CLK);
    #1;
    Reset    = 1'b0;
    ack_seen = 0;
    repeat (6) begin
      @(negedge CLK);
      if (cpu_ack || dbg_ack) ack_seen++;
    end
    chk("ack_after_abort", 33'(ack_seen), 33'(0));
    @(posedge CLK);
    #1;
    xfer(1'b0, 32'd8, 2, 1'b0);

`ifdef IMEM_FETCH_STATS_EN
    do_reset();
    xfer(1'b0, 32'd0,   2, 1'b0);
    xfer(1'b1, 32'd4,   2, 1'b0);
    xfer(1'b0, 32'd252, 2, 1'b0);
    xfer(1'b0, 32'd2,   1, 1'b0);
    xfer(1'b1, 32'd256, 1, 1'b0);
    chk("fetch_cnt", 33'(fetch_cnt), 33'(5));
    chk("fault_cnt", 33'(fault_cnt), 33'(2));
`endif

    // Randomized concurrent traffic on both ports.
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        xfer(1'b0, rand_addr(), -1, 1'b0);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
        xfer(1'b1, rand_addr(), -1, 1'b0);
      end
    join

    repeat (5) @(posedge CLK);
    chk("cpu_q_drained", 33'(cpu_q.size()), 33'(0));
    chk("dbg_q_drained", 33'(dbg_q.size()), 33'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
